// File: rtl/cir_q_pkg.sv
// Shared constants and types for the circular-queue allocation/commit controller.
package cir_q_pkg;

  localparam int CIR_Q_S_INDEX = 5;
  localparam int CIR_Q_DEPTH   = 2 ** CIR_Q_S_INDEX;

  typedef logic [CIR_Q_S_INDEX-1:0] cir_q_tag_t;
  typedef logic [CIR_Q_S_INDEX:0]   cir_q_ptr_t;

endpackage

// File: rtl/cir_q_ptr.sv
// Wrapping queue pointer: index in the low bits, wrap flag in the MSB.
module cir_q_ptr
  import cir_q_pkg::*;
#(
  parameter int S_INDEX = CIR_Q_S_INDEX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [S_INDEX:0] ptr
);

  logic [S_INDEX:0] ptr_r;

  // Pointer register; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= {(S_INDEX+1){1'b0}};
    end else if (clr) begin
      ptr_r <= {(S_INDEX+1){1'b0}};
    end else if (inc) begin
      ptr_r <= ptr_r + {{S_INDEX{1'b0}}, 1'b1};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/cir_q_ctrl.sv
// Circular-queue allocation/commit controller: tags out at the tail, in-order retire at the head.
// Optional CIR_Q_WB_BYPASS_EN lets a writeback to the head commit in the same cycle.
module cir_q_ctrl
  import cir_q_pkg::*;
#(
  parameter int S_INDEX = CIR_Q_S_INDEX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  output logic [S_INDEX-1:0] enq_tag,
  input  logic               wb_valid,
  input  logic [S_INDEX-1:0] wb_tag,
  output logic               commit_valid,
  input  logic               commit_ready,
  output logic [S_INDEX-1:0] commit_tag,
  output logic               array_write,
  output logic [S_INDEX-1:0] array_windex,
  output logic [S_INDEX:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** S_INDEX;

  logic [S_INDEX:0]   head_s;
  logic [S_INDEX:0]   tail_s;
  logic [S_INDEX-1:0] head_idx_s;
  logic [S_INDEX-1:0] tail_idx_s;
  logic [DEPTH-1:0]   valid_r;
  logic [DEPTH-1:0]   done_r;
  logic               empty_s;
  logic               full_s;
  logic               enq_fire_s;
  logic               wb_fire_s;
  logic               commit_valid_s;
  logic               commit_fire_s;

  cir_q_ptr #(.S_INDEX(S_INDEX)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (commit_fire_s),
    .ptr (head_s)
  );

  cir_q_ptr #(.S_INDEX(S_INDEX)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (enq_fire_s),
    .ptr (tail_s)
  );

  // Status, handshake qualification; flush masks every side effect in its cycle.
  always_comb begin
    head_idx_s = head_s[S_INDEX-1:0];
    tail_idx_s = tail_s[S_INDEX-1:0];
    empty_s    = (head_s == tail_s);
    full_s     = (head_idx_s == tail_idx_s) && (head_s[S_INDEX] != tail_s[S_INDEX]);
    enq_fire_s = enq_valid & ~full_s & ~flush;
    wb_fire_s  = wb_valid & valid_r[wb_tag] & ~flush;
`ifdef CIR_Q_WB_BYPASS_EN
    commit_valid_s = ((~empty_s & done_r[head_idx_s]) |
                      (wb_valid & (wb_tag == head_idx_s) & valid_r[head_idx_s])) & ~flush;
`else
    commit_valid_s = ~empty_s & done_r[head_idx_s] & ~flush;
`endif
    commit_fire_s = commit_valid_s & commit_ready;
  end

  // Per-entry valid/done; head and tail indices never collide when both fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
    end else if (flush) begin
      valid_r <= {DEPTH{1'b0}};
      done_r  <= {DEPTH{1'b0}};
    end else begin
      if (wb_fire_s) begin
        done_r[wb_tag] <= 1'b1;
      end else begin
        done_r[wb_tag] <= done_r[wb_tag];
      end
      // Retire after writeback so a same-cycle writeback to the head leaves no stale done bit.
      if (commit_fire_s) begin
        valid_r[head_idx_s] <= 1'b0;
        done_r[head_idx_s]  <= 1'b0;
      end else begin
        valid_r[head_idx_s] <= valid_r[head_idx_s];
      end
      if (enq_fire_s) begin
        valid_r[tail_idx_s] <= 1'b1;
        done_r[tail_idx_s]  <= 1'b0;
      end else begin
        valid_r[tail_idx_s] <= valid_r[tail_idx_s];
      end
    end
  end

  assign enq_ready    = ~full_s;
  assign enq_tag      = tail_idx_s;
  assign array_write  = enq_fire_s;
  assign array_windex = tail_idx_s;
  assign commit_valid = commit_valid_s;
  assign commit_tag   = head_idx_s;
  assign count        = tail_s - head_s;
  assign full         = full_s;
  assign empty        = empty_s;

endmodule

// File: tb/tb_cir_q_ctrl.sv
// Scoreboard bench for cir_q_ctrl: allocated tags queued on array_write, popped on commit.
module tb_cir_q_ctrl;
  import cir_q_pkg::*;

  localparam int SI    = CIR_Q_S_INDEX;
  localparam int DEPTH = CIR_Q_DEPTH;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       enq_valid = 1'b0;
  logic       wb_valid = 1'b0;
  cir_q_tag_t wb_tag = '0;
  logic       commit_ready = 1'b0;
  logic       enq_ready, commit_valid, array_write, full, empty;
  cir_q_tag_t enq_tag, commit_tag, array_windex;
  logic [SI:0] count;

  int n_checks = 0;
  int n_pass = 0;
  int n_commits = 0;
  cir_q_tag_t exp_q[$];
  cir_q_tag_t m_tail = '0;
  cir_q_tag_t mon_t;
  logic       mon_aw;

  cir_q_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_tag(enq_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .array_write(array_write), .array_windex(array_windex),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor, sampling 1 time unit before each rising edge.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      exp_q.delete();
      m_tail = '0;
    end else if (flush) begin
      n_checks++;
      if (array_write !== 1'b0 || commit_valid !== 1'b0)
        $display("FAIL flush_suppress array_write=%b commit_valid=%b required 0 0", array_write, commit_valid);
      else n_pass++;
      exp_q.delete();
      m_tail = '0;
    end else begin
      mon_aw = enq_valid && (exp_q.size() < DEPTH);
      n_checks++;
      if (array_write !== mon_aw) $display("FAIL array_write got %b want %b", array_write, mon_aw);
      else n_pass++;
      if (commit_valid === 1'b1 && commit_ready === 1'b1) begin
        n_commits++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL commit_unexpected tag %0d with empty scoreboard", commit_tag);
        else begin
          mon_t = exp_q.pop_front();
          if (commit_tag !== mon_t) $display("FAIL commit_tag got %0d want %0d", commit_tag, mon_t);
          else n_pass++;
        end
      end
      if (array_write === 1'b1) begin
        n_checks++;
        if (enq_tag !== m_tail) $display("FAIL enq_tag got %0d want %0d", enq_tag, m_tail);
        else n_pass++;
        exp_q.push_back(m_tail);
        m_tail = m_tail + 1'b1;
      end
    end
  end

  task automatic drive(input logic ev, input logic wv, input cir_q_tag_t wt, input logic cr, input logic fl);
    enq_valid = ev; wb_valid = wv; wb_tag = wt; commit_ready = cr; flush = fl;
    @(negedge clk);
  endtask

  task automatic test_reset();
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
    n_checks++; if (count !== 6'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (enq_ready !== 1'b1) $display("FAIL reset_enq_ready got %b want 1", enq_ready); else n_pass++;
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL reset_commit_valid got %b want 0", commit_valid); else n_pass++;
    n_checks++; if (array_write !== 1'b0) $display("FAIL reset_array_write got %b want 0", array_write); else n_pass++;
    n_checks++; if (enq_tag !== 5'd0 || array_windex !== 5'd0 || commit_tag !== 5'd0)
      $display("FAIL reset_tags got %0d/%0d/%0d want 0/0/0", enq_tag, array_windex, commit_tag);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else n_pass++;
    n_checks++; if (enq_ready !== 1'b0) $display("FAIL fill_enq_ready got %b want 0", enq_ready); else n_pass++;
    n_checks++; if (count !== 6'd32) $display("FAIL fill_count got %0d want 32", count); else n_pass++;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    n_checks++; if (array_windex !== 5'd0) $display("FAIL overfill_tail got %0d want 0", array_windex); else n_pass++;
    n_checks++; if (count !== 6'd32) $display("FAIL overfill_count got %0d want 32", count); else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    n_checks++; if (empty !== 1'b1) $display("FAIL fill_flush_empty got %b want 1", empty); else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_ooo_writeback();
    int c0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL ooo_wb2_commit_valid got %b want 0", commit_valid); else n_pass++;
    drive(1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL ooo_wb1_commit_valid got %b want 0", commit_valid); else n_pass++;
    c0 = n_commits;
    drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd0)
      $display("FAIL ooo_wb0_visible got valid=%b tag=%0d want 1 tag 0", commit_valid, commit_tag);
    else n_pass++;
    n_checks++; if (n_commits !== c0) $display("FAIL ooo_early_commit got %0d commits want %0d", n_commits, c0); else n_pass++;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_checks++; if (n_commits !== c0 + 3) $display("FAIL ooo_commit_count got %0d want %0d", n_commits, c0 + 3); else n_pass++;
    n_checks++; if (empty !== 1'b1) $display("FAIL ooo_empty got %b want 1", empty); else n_pass++;
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 31; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 31; i++) drive(1'b0, 1'b1, cir_q_tag_t'(i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b1, cir_q_tag_t'(30 + k), 1'b1, 1'b0);
      n_checks++; if (count !== 6'd31) $display("FAIL b2b_count cycle %0d got %0d want 31", k, count); else n_pass++;
    end
    n_checks++; if (commit_tag !== 5'd8 || array_windex !== 5'd7)
      $display("FAIL b2b_wrap_ptrs got head %0d tail %0d want 8 7", commit_tag, array_windex);
    else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_wb_unallocated();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, cir_q_tag_t'(i), 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1 || commit_tag !== 5'd7)
      $display("FAIL unalloc_setup got empty=%b head=%0d want 1 7", empty, commit_tag);
    else n_pass++;
    drive(1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (commit_valid !== 1'b0) $display("FAIL unalloc_not_done got %b want 0", commit_valid); else n_pass++;
    end
    drive(1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd7)
      $display("FAIL unalloc_fresh_wb got valid=%b tag=%0d want 1 7", commit_valid, commit_tag);
    else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1) $display("FAIL unalloc_drain got %b want 1", empty); else n_pass++;
    drive(1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    n_checks++; if (commit_valid !== 1'b0) $display("FAIL same_cycle_wb_enq got %b want 0", commit_valid); else n_pass++;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_flush_reset();
    int c0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, cir_q_tag_t'(i), 1'b0, 1'b0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    n_checks++; if (commit_valid !== 1'b1 || commit_tag !== 5'd0)
      $display("FAIL hold_stable got valid=%b tag=%0d want 1 0", commit_valid, commit_tag);
    else n_pass++;
    c0 = n_commits;
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    n_checks++; if (empty !== 1'b1 || count !== 6'd0)
      $display("FAIL flush_state got empty=%b count=%0d want 1 0", empty, count);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      n_checks++; if (commit_valid !== 1'b0) $display("FAIL flush_no_commit got %b want 0", commit_valid); else n_pass++;
    end
    n_checks++; if (n_commits !== c0) $display("FAIL flush_commits got %0d want %0d", n_commits, c0); else n_pass++;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    enq_valid = 1'b0;
    #1;
    n_checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 6'd0 || enq_ready !== 1'b1)
      $display("FAIL async_reset_status got empty=%b full=%b count=%0d ready=%b want 1 0 0 1", empty, full, count, enq_ready);
    else n_pass++;
    n_checks++; if (commit_valid !== 1'b0 || array_write !== 1'b0 || array_windex !== 5'd0 || commit_tag !== 5'd0)
      $display("FAIL async_reset_outs got cv=%b aw=%b widx=%0d ctag=%0d want 0 0 0 0", commit_valid, array_write, array_windex, commit_tag);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_fill();
    test_ooo_writeback();
    test_back_to_back();
    test_wb_unallocated();
    test_flush_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cir_q_ctrl.md
Name: cir_q_ctrl

Overview:
- Allocation/commit controller for the circular queue data array in the OOO core's reorder/commit path.
- Owns head/tail pointers, occupancy and per-entry valid/done bits.
- Drives the array's write strobe, write index and commit index.
- Hands out entry tags to dispatch, accepts writeback completions by tag, and retires entries in order at the head under a valid/ready handshake.

Parameters:
- S_INDEX, 5, log2 of queue depth; DEPTH = 2**S_INDEX entries (32).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- flush  in  1  synchronous squash of all entries
- enq_valid  in  1  dispatch requests an entry
- enq_ready  out  1  entry available (= !full)
- enq_tag  out  S_INDEX  index allocated on accept (= tail)
- wb_valid  in  1  completion strobe
- wb_tag  in  S_INDEX  completing entry index
- commit_valid  out  1  head entry valid and done
- commit_ready  in  1  consumer accepts head
- commit_tag  out  S_INDEX  head index; wired to the array's commit_index
- array_write  out  1  = enq_valid & enq_ready
- array_windex  out  S_INDEX  = tail
- count  out  S_INDEX+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Pointers: head and tail are S_INDEX+1 bits; low bits give the index, MSB is the wrap bit.
  - empty = pointers equal.
  - full = index equal, wrap bits differ.
  - count = tail - head, modulo 2**(S_INDEX+1).
- Reset (rst low, asynchronous): head = tail = 0; all valid/done = 0.
  - Outputs after reset: empty = 1, full = 0, count = 0, enq_ready = 1, commit_valid = 0, array_write = 0, enq_tag = array_windex = commit_tag = 0.
  - Reset asserted mid-operation discards all state immediately.
- Enqueue accept (enq_valid & enq_ready): valid[tail] = 1, done[tail] = 0, tail++.
  - Index wraps DEPTH-1 -> 0 and the wrap bit toggles.
  - No enqueue while full, even if a commit occurs the same cycle; no bypass.
- Writeback (wb_valid): if valid[wb_tag], done[wb_tag] = 1; otherwise ignored.
- Commit:
  - commit_valid = !empty & done[head], taken from registered state.
  - A writeback to head becomes commit-visible the next cycle.
  - On commit_valid & commit_ready: valid[head] = 0, done[head] = 0, head++.
  - commit_valid/commit_tag stay stable while commit_ready is low.
- Simultaneous events:
  - Enqueue + commit in the same cycle: count unchanged, both pointers advance.
  - Writeback + commit of the same entry: a no-op, since the entry is already done.
  - Writeback to the entry being enqueued the same cycle: ignored; the entry is not yet valid.
- Flush: synchronous; priority over enqueue, writeback and commit.
  - Next cycle head = tail = 0 and all valid/done bits are cleared.
  - array_write and the commit handshake are suppressed in the flush cycle.
- Latency:
  - Allocation to array write: same cycle.
  - Writeback to commit_valid: 1 cycle.
  - Commit throughput: 1 entry per cycle.

Optional Feature:
- Macro: CIR_Q_WB_BYPASS_EN.
- Defined: commit_valid also asserts when wb_valid & (wb_tag == head) & valid[head] & !flush, so writeback-to-commit latency is 0 cycles. This creates a combinational path from wb_tag to commit_valid.
- Undefined: commit_valid is purely registered as described above.

Decomposition:
- Shared package cir_q_pkg holds:
  - CIR_Q_S_INDEX and CIR_Q_DEPTH constants.
  - typedef cir_q_tag_t, logic [S_INDEX-1:0].
  - typedef cir_q_ptr_t, logic [S_INDEX:0].
- One sub-module, cir_q_ptr: a wrapping pointer register with increment enable and synchronous clear. It is instantiated twice, for head and tail.

Test Plan:
- Reset then idle -> empty = 1, count = 0, enq_ready = 1, commit_valid = 0, all tags 0.
- Enqueue 32 back-to-back -> enq_tag 0..31 in order; full = 1 and enq_ready = 0 after the 32nd; a 33rd enq_valid is not accepted and tail stays put.
- Fill 3 entries, writeback tags 2 then 1 then 0 with commit_ready = 1 -> no commit until tag 0 is done; then tags 0, 1, 2 commit on consecutive cycles; empty = 1 afterwards.
- Steady state at count 31: enqueue + commit every cycle for 40 cycles -> count stays 31, both pointers wrap past 31 -> 0, enq_tag sequence continues 31, 0, 1, ...
- Writeback to an unallocated tag 7 while empty, then enqueue to tag 7 -> entry 7 is not done; commit_valid stays 0 until a fresh writeback.
- With 5 entries all done and commit_ready held low, assert flush -> next cycle empty = 1, no commit ever occurs; then assert rst low mid-enqueue -> all outputs return to reset values asynchronously.
